// File: rtl/noc_pkt_injector.sv
// noc_pkt_injector: turns a packet request (destination + length) plus a
// stream of payload beats into typed NoC flits (HEAD/BODY/TAIL/SINGLE).
// Requests with an out-of-range destination are consumed and dropped, and
// err_dst pulses once for each of them.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_dst, req_len              destination ID, beat count minus one
//   data_valid/data_ready, data   payload beat handshake and beat value
//   flit_valid/flit_ready         output flit handshake
//   flit_type                     {head,tail} flit type
//   flit_dst, flit_data           flit destination and payload
//   err_dst                       one-cycle pulse for a bad destination
module noc_pkt_injector #(
    parameter int unsigned DST_ADDR_WIDTH = 2,
    parameter int unsigned NUM_DST        = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned LEN_WIDTH      = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [DST_ADDR_WIDTH-1:0] req_dst,
    input  logic [LEN_WIDTH-1:0]      req_len,
    input  logic                      data_valid,
    output logic                      data_ready,
    input  logic [DATA_WIDTH-1:0]     data,
    output logic                      flit_valid,
    input  logic                      flit_ready,
    output logic [1:0]                flit_type,
    output logic [DST_ADDR_WIDTH-1:0] flit_dst,
    output logic [DATA_WIDTH-1:0]     flit_data,
    output logic                      err_dst
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_TAIL   = 2'b01;
    localparam logic [1:0] T_HEAD   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic [1:0]                state;
    logic [1:0]                state_nxt;
    logic [DST_ADDR_WIDTH-1:0] dst_q;
    logic [LEN_WIDTH-1:0]      len_q;
    logic [LEN_WIDTH-1:0]      cnt;
    logic                      req_fire;
    logic                      beat_fire;
    logic                      last_beat;
    logic                      dst_ok;
    logic [1:0]                beat_type;

    assign req_fire  = req_valid && req_ready;
    assign beat_fire = data_valid && data_ready;
    assign last_beat = (cnt == len_q);
    assign dst_ok    = (32'(req_dst) < NUM_DST);

    // Flit type of the beat currently being accepted.
    always_comb begin
        beat_type = T_BODY;
        if (len_q == '0) begin
            beat_type = T_SINGLE;
        end else if (cnt == '0) begin
            beat_type = T_HEAD;
        end else if (last_beat) begin
            beat_type = T_TAIL;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake-ready decode. data_ready in SEND depends on
    // flit_ready so a draining flit can be replaced in the same cycle.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        data_ready = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = dst_ok ? S_SEND : S_DROP;
                end
            end
            S_SEND: begin
                data_ready = !flit_valid || flit_ready;
                if (beat_fire && last_beat) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DROP: begin
                data_ready = 1'b1;
                if (beat_fire && last_beat) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Request latch and beat counter; the counter holds on the last beat so
    // it never wraps inside a packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_q <= '0;
            len_q <= '0;
            cnt   <= '0;
        end else if (req_fire) begin
            dst_q <= req_dst;
            len_q <= req_len;
            cnt   <= '0;
        end else if (beat_fire && !last_beat) begin
            cnt <= cnt + LEN_WIDTH'(1);
        end
    end

    // Bad-destination pulse, one cycle after the request is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_dst <= 1'b0;
        end else begin
            err_dst <= req_fire && !dst_ok;
        end
    end

    // Single output flit register; a load wins over a simultaneous drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_valid <= 1'b0;
            flit_type  <= '0;
            flit_dst   <= '0;
            flit_data  <= '0;
        end else if (beat_fire && (state == S_SEND)) begin
            flit_valid <= 1'b1;
            flit_type  <= beat_type;
            flit_dst   <= dst_q;
            flit_data  <= data;
        end else if (flit_valid && flit_ready) begin
            flit_valid <= 1'b0;
        end
    end

endmodule

// File: doc/noc_pkt_injector.md
NOC_PKT_INJECTOR -- requirements
Module: noc_pkt_injector

Interface
REQ-001 SHALL have parameter DST_ADDR_WIDTH, default 2, width of destination ID field consumed by downstream routing.
REQ-002 SHALL have parameter NUM_DST, default 4, number of valid destinations (IDs 0..NUM_DST-1).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, payload width per flit.
REQ-004 SHALL have parameter LEN_WIDTH, default 3, width of beat-count field (packet = len+1 beats, max 2^LEN_WIDTH).
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, 1, packet request valid.
REQ-008 SHALL have port req_ready, output, 1, request accepted when req_valid && req_ready.
REQ-009 SHALL have port req_dst, input, DST_ADDR_WIDTH, destination ID.
REQ-010 SHALL have port req_len, input, LEN_WIDTH, beats minus one.
REQ-011 SHALL have port data_valid, input, 1, payload beat valid.
REQ-012 SHALL have port data_ready, output, 1, beat accepted when data_valid && data_ready.
REQ-013 SHALL have port data, input, DATA_WIDTH, payload beat.
REQ-014 SHALL have port flit_valid, output, 1, output flit valid.
REQ-015 SHALL have port flit_ready, input, 1, downstream accepts flit when flit_valid && flit_ready.
REQ-016 SHALL have port flit_type, output, 2, {head,tail}: 10 HEAD, 00 BODY, 01 TAIL, 11 SINGLE.
REQ-017 SHALL have port flit_dst, output, DST_ADDR_WIDTH, destination ID of packet, constant across all its flits.
REQ-018 SHALL have port flit_data, output, DATA_WIDTH, payload.
REQ-019 SHALL have port err_dst, output, 1, one-cycle pulse on acceptance of a request with req_dst >= NUM_DST.

Function
REQ-020 SHALL implement FSM states IDLE, SEND, DROP.
REQ-021 IDLE: req_ready=1, data_ready=0; on request handshake latch req_dst, req_len, clear beat counter; go SEND if req_dst < NUM_DST, else DROP and assert err_dst next cycle for one cycle.
REQ-022 SEND: req_ready=0; data_ready = !flit_valid || flit_ready (single output register, no bubble under continuous flow).
REQ-023 SEND: each accepted beat SHALL load output register with data, latched dst, and type: SINGLE if len==0; HEAD if cnt==0, len>0; TAIL if cnt==len, len>0; BODY otherwise.
REQ-024 Latency: beat accepted in cycle t SHALL appear on flit_* with flit_valid=1 in cycle t+1.
REQ-025 flit_valid SHALL stay 1 and flit_type/dst/data SHALL stay stable until flit_ready handshake.
REQ-026 Beat counter SHALL increment per accepted beat; on beat with cnt==len return to IDLE next cycle; counter never wraps within a packet.
REQ-027 DROP: data_ready=1, flit register untouched; beats consumed and discarded; after beat cnt==len return to IDLE.
REQ-028 Simultaneous flit_ready drain and new beat load in same cycle SHALL be allowed (flit_valid stays 1).
REQ-029 A pending flit from previous packet SHALL NOT block acceptance of the next request in IDLE; it blocks only new beats per REQ-022.
REQ-030 flit_dst SHALL be zero-extended/equal to latched req_dst; no routing decode performed in this block.

Reset
REQ-031 rst_n low SHALL asynchronously force state IDLE, counter 0, flit_valid 0, err_dst 0, flit_type/dst/data 0.
REQ-032 Reset mid-packet SHALL discard in-flight packet and any pending flit; after release block accepts a new request in IDLE.
REQ-033 Outputs req_ready=1, data_ready=0 during and immediately after reset.

Verification
REQ-034 Single: req dst=2 len=0, beat 0xA5A5A5A5, flit_ready=1 -> one flit type=11, dst=2, data=0xA5A5A5A5, one cycle after beat.
REQ-035 Burst: dst=1 len=3, beats 1,2,3,4 back-to-back, flit_ready=1 -> types 10,00,00,01, dst=1, data 1..4, four consecutive cycles.
REQ-036 Backpressure: len=3, flit_ready=0 for 5 cycles after first flit -> data_ready=0, flit held stable, no beat lost; resume yields 4 flits in order.
REQ-037 Bad dst: NUM_DST=3, req dst=3 len=1 -> err_dst pulse once, 2 beats consumed, flit_valid stays 0, next request accepted.
REQ-038 Reset mid-packet: len=7, rst_n low after beat 3 -> flit_valid=0, req_ready=1; new dst=0 len=0 packet emits type=11.
